round_key_gen: RTL

Key-schedule generator for the Grasshopper (GOST R 34.12-2015) encoder. It accepts a 256-bit master key and produces the ten 128-bit round keys K1..K10 with an iterative Feistel network: 32 LSX iterations, one per clock. It sits directly upstream of the per-round key XOR stage and supplies the round key for each `stage_num`.

---
 rtl/round_key_gen.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/round_key_gen.sv
// Grasshopper (GOST R 34.12-2015) key schedule: a 256-bit master key is
// expanded into round keys K1..K10 by 32 Feistel LSX steps, one per clock.
// Ports: clk, rst (async, active low); key_valid_i/key_ready_o/key_i take
// the master key; rk_valid_o/rk_ready_i/rk_index_o/rk_o stream the keys.
// Optional macro GRASSHOPPER_KEYGEN_STORE_EN adds a 10-entry key store
// read through rd_idx_i/rd_key_o (index 0 and 11..15 read as zero).
module round_key_gen (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic [255:0] key_i,
   output logic         rk_valid_o,
   input  logic         rk_ready_i,
   output logic [3:0]   rk_index_o,
   output logic [127:0] rk_o
`ifdef GRASSHOPPER_KEYGEN_STORE_EN
   ,
   input  logic [3:0]   rd_idx_i,
   output logic [127:0] rd_key_o
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EMA  = 2'd1;
   localparam logic [1:0] S_EMB  = 2'd2;
   localparam logic [1:0] S_ITER = 2'd3;

   // pi substitution, byte 0x00 in the top byte
   localparam logic [2047:0] PI = {
      128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
      128'hE977F0DB932E99BA1736F1BB14CD5FC1,
      128'hF918655AE25CEF21811C3C428B018E4F,
      128'h058402AEE36A8FA0060BED987FD4D31F,
      128'hEB342C51EAC848ABF22A68A2FD3ACECC,
      128'hB5700E56080C7612BF7213479CB75D87,
      128'h15A19629107B9AC7F391786F9D9EB2B1,
      128'h3275193DFF358A7E6D54C680C3BD0D57,
      128'hDFF524A93EA843C9D779D6F67C22B903,
      128'hE00FECDE7A94B0BCDCE828504E330A4A,
      128'hA79760731E0062441AB83882649F2641,
      128'hAD454692275E552F8CA3A57D69D5953B,
      128'h0758B34086AC1DF730376BE488D9E789,
      128'hE11B83494C3FF8FE8D53AA90CAD88561,
      128'h207167A42D2B095BCB9B25D0BEE56C52,
      128'h59A674D2E6F4B4C0D166AFC2394B63B6
   };

   // l() coefficient for byte j sits at bits [8j+7:8j]
   localparam logic [127:0] LCOEF =
      128'h942085_10C2C001FB01C0C2_10852094_01;

   function automatic logic [7:0] gf_mul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] r;
      logic [7:0] x;
      r = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [127:0] l_fn(input logic [127:0] a);
      logic [127:0] v;
      logic [7:0]   t;
      v = a;
      for (int r = 0; r < 16; r++) begin
         t = '0;
         for (int j = 0; j < 16; j++)
            t = t ^ gf_mul(v[8*j +: 8], LCOEF[8*j +: 8]);
         v = {t, v[127:8]};
      end
      return v;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return PI[8*(255 - int'(x)) +: 8];
   endfunction

   logic [1:0]   state;
   logic [127:0] a1;
   logic [127:0] a0;
   logic [4:0]   ci;
   logic [2:0]   p;
   logic [127:0] rk_q;
   logic [3:0]   idx_q;

   // ci is 5 bits, so C[32] lives at entry 0
   logic [127:0] c_rom [32];
   for (genvar g = 0; g < 32; g++) begin : g_rom
      assign c_rom[g] = l_fn(128'(g == 0 ? 32 : g));
   end

   logic [127:0] xs;
   logic [127:0] ss;
   logic [127:0] step;

   always_comb begin
      xs = a1 ^ c_rom[ci];
      ss = '0;
      for (int j = 0; j < 16; j++)
         ss[8*j +: 8] = sbox(xs[8*j +: 8]);
      step = l_fn(ss) ^ a0;
   end

   wire accept = key_valid_i && (state == S_IDLE);
   wire xfer   = rk_valid_o && rk_ready_i;

   assign key_ready_o = (state == S_IDLE);
   assign rk_valid_o  = (state == S_EMA) || (state == S_EMB);
   assign rk_o        = rk_q;
   assign rk_index_o  = idx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         a1    <= '0;
         a0    <= '0;
         ci    <= '0;
         p     <= '0;
         rk_q  <= '0;
         idx_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (accept) begin
               a1    <= key_i[255:128];
               a0    <= key_i[127:0];
               p     <= 3'd1;
               ci    <= 5'd1;
               rk_q  <= key_i[255:128];
               idx_q <= 4'd1;
               state <= S_EMA;
            end
            S_EMA: if (rk_ready_i) begin
               rk_q  <= a0;
               idx_q <= {p, 1'b0};
               state <= S_EMB;
            end
            S_EMB: if (rk_ready_i) begin
               rk_q  <= '0;
               idx_q <= '0;
               state <= (p == 3'd5) ? S_IDLE : S_ITER;
            end
            S_ITER: begin
               a1 <= step;
               a0 <= a1;
               ci <= ci + 5'd1;
               // eighth step of the pair: next odd key is the new a1
               if (ci[2:0] == 3'd0) begin
                  p     <= p + 3'd1;
                  rk_q  <= step;
                  idx_q <= {p, 1'b0} + 4'd1;
                  state <= S_EMA;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef GRASSHOPPER_KEYGEN_STORE_EN
   logic [127:0] store [10];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 10; i++) store[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < 10; i++) store[i] <= '0;
      end else if (xfer) begin
         store[idx_q - 4'd1] <= rk_q;
      end
   end

   always_comb begin
      rd_key_o = '0;
      if (rd_idx_i >= 4'd1 && rd_idx_i <= 4'd10)
         rd_key_o = store[rd_idx_i - 4'd1];
   end
`endif

endmodule
